// File: rtl/serial_binary_adder.sv
// Bit-serial adder: one full-adder slice plus a carry flop computes a + b + cin, LSB first.
// Optional signed-overflow output is compiled in with `define SERIAL_ADDER_OVF_EN.
module serial_binary_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       state_dbg
);

  // Handshake: start is accepted on any edge where busy is low (IDLE or DONE);
  // done pulses for one cycle, and sum/cout hold that result until the next done.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic [WIDTH-1:0] s_sr_next;
  logic [CW-1:0]    count;
  logic             carry;
  logic             carry_next;
  logic             s_bit;
  logic             load;

  assign state_dbg  = state;
  assign load       = start && (state != SHIFT);
  assign s_bit      = a_sr[0] ^ b_sr[0] ^ carry;
  assign carry_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  // New sum bit enters at the MSB so the LSB-first stream ends up in place.
  assign s_sr_next  = (s_sr >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (count == LAST) state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      count <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      state <= state_next;
      busy  <= (state_next == SHIFT);
      done  <= (state_next == DONE);
      if (load) begin
        a_sr  <= a;
        b_sr  <= b;
        carry <= cin;
        count <= '0;
      end else if (state == SHIFT) begin
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        s_sr  <= s_sr_next;
        carry <= carry_next;
        count <= count + CW'(1);
        if (count == LAST) begin
          sum  <= s_sr_next;
          cout <= carry_next;
`ifdef SERIAL_ADDER_OVF_EN
          // carry still holds the carry into the MSB while the last bit is summed.
          ovf  <= carry ^ carry_next;
`endif
        end
      end
    end
  end

endmodule
